// File: rtl/serial_shift_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serial_shift_unit                                             |
// | Brief    : Loadable shift register with an automatic WIDTH-step run      |
// |            sequencer (IDLE -> RUN -> DONE). Define the macro             |
// |            SERIAL_SHIFT_ROTATE_EN to make mode 11 rotate right;          |
// |            otherwise mode 11 holds.                                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module serial_shift_unit #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count
);

  localparam logic [1:0]    c_mode_hold = 2'b00;
  localparam logic [1:0]    c_mode_shr  = 2'b01;
  localparam logic [1:0]    c_mode_shl  = 2'b10;
`ifdef SERIAL_SHIFT_ROTATE_EN
  localparam logic [1:0]    c_mode_rotr = 2'b11;
`endif
  localparam logic [CW-1:0] c_last_step = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_nxt;
  logic [WIDTH-1:0] w_step_out;
  logic             r_sout;
  logic             w_sout_nxt;
  logic             w_step_sout;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_nxt;
  logic             r_busy;
  logic             r_done;

  // One step of the datapath, always driven by the mode latched at start.
  always_comb begin
    w_step_out  = r_out;
    w_step_sout = r_sout;
    case (r_mode)
      c_mode_hold: ;
      c_mode_shr: begin
        w_step_out  = {sin, r_out[WIDTH-1:1]};
        w_step_sout = r_out[0];
      end
      c_mode_shl: begin
        w_step_out  = {r_out[WIDTH-2:0], sin};
        w_step_sout = r_out[WIDTH-1];
      end
`ifdef SERIAL_SHIFT_ROTATE_EN
      c_mode_rotr: begin
        w_step_out  = {r_out[0], r_out[WIDTH-1:1]};
        w_step_sout = r_out[0];
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_sout_nxt  = r_sout;
    w_count_nxt = r_count;
    w_mode_nxt  = r_mode;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_out_nxt = in;
        end
        if (start) begin
          w_state_nxt = S_RUN;
          w_count_nxt = '0;
          w_mode_nxt  = mode;
        end
      end
      S_RUN: begin
        w_out_nxt  = w_step_out;
        w_sout_nxt = w_step_sout;
        if (r_count == c_last_step) begin
          w_state_nxt = S_DONE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // busy/done come from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out   <= '0;
      r_sout  <= 1'b0;
      r_count <= '0;
      r_mode  <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_out   <= w_out_nxt;
      r_sout  <= w_sout_nxt;
      r_count <= w_count_nxt;
      r_mode  <= w_mode_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign out   = r_out;
  assign sout  = r_sout;
  assign busy  = r_busy;
  assign done  = r_done;
  assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_serial_shift_unit.sv
`default_nettype none
// Randomized self-checking bench for serial_shift_unit; expected values come
// from an arithmetic model of the register contents per run step.
module tb_serial_shift_unit;

  localparam int W   = 8;
  localparam int CWB = $clog2(W);

  logic           clk;
  logic           rst;
  logic           load;
  logic           start;
  logic [1:0]     mode;
  logic           sin;
  logic [W-1:0]   in;
  logic [W-1:0]   out;
  logic           sout;
  logic           busy;
  logic           done;
  logic [CWB-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] m_out;
  logic         m_sout;

  serial_shift_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .start (start),
    .mode  (mode),
    .sin   (sin),
    .in    (in),
    .out   (out),
    .sout  (sout),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic b, input logic d, input int c);
    check({tag, ".out"},   64'(out),   64'(m_out));
    check({tag, ".sout"},  64'(sout),  64'(m_sout));
    check({tag, ".busy"},  64'(busy),  64'(b));
    check({tag, ".done"},  64'(done),  64'(d));
    check({tag, ".count"}, 64'(count), 64'(c));
  endtask

  // Reference step: plain arithmetic on the register value.
  task automatic model_step(input logic [1:0] md, input logic s);
    logic [W-1:0] msb;
    msb = 1 << (W - 1);
    case (md)
      2'b01: begin
        m_sout = m_out[0];
        m_out  = (m_out >> 1) | (s ? msb : '0);
      end
      2'b10: begin
        m_sout = m_out[W-1];
        m_out  = W'((m_out << 1) | W'(s));
      end
      2'b11: begin
`ifdef SERIAL_SHIFT_ROTATE_EN
        m_sout = m_out[0];
        m_out  = (m_out >> 1) | (m_out[0] ? msb : '0);
`endif
      end
      default: ;
    endcase
  endtask

  // sin_sel: 0/1 fixed serial input, 2 random; abort_at: step to reset on (0 = none)
  task automatic run(input logic [W-1:0] val, input bit pre_load, input bit co_load,
                     input logic [1:0] md, input int sin_sel, input int abort_at);
    if (pre_load) begin
      load  = 1'b1;
      start = 1'b0;
      in    = val;
      tick();
      load  = 1'b0;
      m_out = val;
      check_all("load", 1'b0, 1'b0, 0);
    end
    load  = co_load;
    in    = val;
    start = 1'b1;
    mode  = md;
    tick();
    if (co_load) m_out = val;
    check_all("start", 1'b1, 1'b0, 0);
    for (int k = 1; k <= W; k++) begin
      // load/start/mode noise during the run must have no effect
      load  = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      in    = W'($urandom);
      mode  = 2'($urandom);
      sin   = (sin_sel == 2) ? 1'($urandom_range(0, 1)) : sin_sel[0];
      if (k == abort_at) begin
        rst = 1'b0;
        tick();
        rst    = 1'b1;
        load   = 1'b0;
        start  = 1'b0;
        m_out  = '0;
        m_sout = 1'b0;
        check_all("abort", 1'b0, 1'b0, 0);
        for (int j = 0; j < 3; j++) begin
          tick();
          check_all("post_abort", 1'b0, 1'b0, 0);
        end
        return;
      end
      tick();
      model_step(md, sin);
      check_all("step", k < W, k == W, k % W);
    end
    load  = 1'b1;
    start = 1'b1;
    in    = W'($urandom);
    tick();
    load  = 1'b0;
    start = 1'b0;
    check_all("done_exit", 1'b0, 1'b0, 0);
    tick();
    check_all("idle", 1'b0, 1'b0, 0);
  endtask

  initial begin
    rst    = 1'b0;
    load   = 1'b0;
    start  = 1'b0;
    mode   = 2'b00;
    sin    = 1'b0;
    in     = '0;
    m_out  = '0;
    m_sout = 1'b0;
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0, 0);
    rst = 1'b1;
    tick();
    check_all("idle0", 1'b0, 1'b0, 0);

    run(8'hA5, 1'b1, 1'b0, 2'b01, 0, 0);
    check("shr_a5_final", 64'(out), 64'h00);

    run(8'h81, 1'b1, 1'b0, 2'b11, 2, 0);
    check("mode11_final", 64'(out), 64'h81);

    run(8'h01, 1'b1, 1'b0, 2'b10, 1, 0);
    check("shl_fill_out", 64'(out), 64'hFF);
    check("shl_fill_sout", 64'(sout), 64'h1);

    run(8'h3C, 1'b0, 1'b1, 2'b01, 2, 0);

    run(W'($urandom), 1'b1, 1'b0, 2'b01, 2, 4);
    run(W'($urandom), 1'b1, 1'b0, 2'b01, 2, 0);

    run(8'h5A, 1'b1, 1'b0, 2'b00, 2, 0);
    check("hold_final", 64'(out), 64'h5A);

    for (int r = 0; r < 40; r++) begin
      run(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          2'($urandom), 2,
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, W)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_shift_unit.md
SERIAL_SHIFT_UNIT -- requirements
Module: serial_shift_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width; legal range 2..64.
REQ-002 The block SHALL have derived parameter CW, default $clog2(WIDTH), giving the width of the count output.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: synchronous, active-low reset.
REQ-005 Port load SHALL be an input, 1 bit: parallel-load request.
REQ-006 Port start SHALL be an input, 1 bit: begin an automatic WIDTH-step shift run.
REQ-007 Port mode SHALL be an input, 2 bits: 00 hold, 01 shift right, 10 shift left, 11 rotate right.
REQ-008 Port sin SHALL be an input, 1 bit: serial input bit, fills the vacated position.
REQ-009 Port in SHALL be an input, WIDTH bits: parallel load data.
REQ-010 Port out SHALL be an output, WIDTH bits: register contents.
REQ-011 Port sout SHALL be an output, 1 bit: last bit shifted or rotated out.
REQ-012 Port busy SHALL be an output, 1 bit: high while in RUN.
REQ-013 Port done SHALL be an output, 1 bit: high for exactly one cycle after a run completes.
REQ-014 Port count SHALL be an output, CW bits: number of steps completed in the current run.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-016 In IDLE with load=1, out SHALL take in on the next edge; sout is unchanged.
REQ-017 In IDLE with start=1, the state SHALL go to RUN, count SHALL go to 0, and mode SHALL be latched for the whole run.
REQ-018 In IDLE with load=1 and start=1 together, out SHALL take in and the state SHALL go to RUN; the first step occurs on the following edge.
REQ-019 In RUN, each edge SHALL perform one step using the latched mode and increment count.
REQ-020 Shift right SHALL set out to {sin, out[WIDTH-1:1]} and sout to old out[0].
REQ-021 Shift left SHALL set out to {out[WIDTH-2:0], sin} and sout to old out[WIDTH-1].
REQ-022 Rotate right SHALL set out to {out[0], out[WIDTH-1:1]} and sout to old out[0]; sin is ignored.
REQ-023 Hold SHALL leave out and sout unchanged while count still advances.
REQ-024 On the step where count equals WIDTH-1, the state SHALL go to DONE and count SHALL wrap to 0.
REQ-025 A run SHALL therefore take exactly WIDTH steps, with busy high for WIDTH cycles.
REQ-026 In DONE, done SHALL be 1 for one cycle, then the state SHALL return to IDLE; no shift occurs in DONE.
REQ-027 load and start SHALL be ignored in RUN and DONE, and a new start SHALL be accepted only in IDLE.
REQ-028 busy and done SHALL never be high together.

Reset
REQ-029 When rst=0 at a rising clk edge, the block SHALL go to IDLE and clear out, sout, count, busy, done and the latched mode to 0.
REQ-030 Reset SHALL take priority over load and start in all states, including mid-run, and any run in progress SHALL be abandoned.
REQ-031 Reset SHALL have no effect between clock edges.

Configuration
REQ-032 Macro SERIAL_SHIFT_ROTATE_EN SHALL control rotate support: when defined, mode 11 performs rotate right per REQ-022.
REQ-033 When SERIAL_SHIFT_ROTATE_EN is undefined, mode 11 SHALL behave as hold per REQ-023, and no rotate datapath SHALL be synthesised.

Verification
REQ-034 With WIDTH=8, load in=8'hA5, then start with mode=01 and sin=0: after 8 steps out=8'h00; sout sequence is 1,0,1,0,0,1,0,1; done pulses once, 9 cycles after start.
REQ-035 With SERIAL_SHIFT_ROTATE_EN defined, load 8'h81, start mode=11: out goes 8'hC0 after step 1, and after 8 steps out=8'h81 with sout=1; with the macro undefined, out stays 8'h81 throughout.
REQ-036 Load 8'h01, start mode=10 with sin=1: out goes 8'h03, 8'h07 … 8'hFF; sout=0 for steps 1..7 and 1 at step 8.
REQ-037 Assert load=1 and start=1 with in=8'h3C in the same IDLE cycle: out=8'h3C first, then 8 right shifts; load=1 with in=8'hFF during RUN is ignored.
REQ-038 Drive rst=0 at step 4 of a run: the next edge gives out=0, busy=0, count=0, done never pulses, and a fresh start afterwards runs all 8 steps.
REQ-039 Start with mode=00: out is unchanged for 8 steps, count runs 0..7, and done pulses once.
